dram_cmd_issuer: RTL and testbench



---
 rtl/dram_cmd_issuer.sv | 188 ++++++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_issuer.sv
// DRAM command issuer: accepts one parsed trace request at a time and emits
// the closed-page command sequence ACT -> RD/WR -> PRE for it.
// Inter-command spacing comes from the T_* parameters, and the next request
// is accepted T_RP cycles after PRE. Command fields are decoded from a fixed
// 33-bit byte-address map and held on the outputs until the next request.
module dram_cmd_issuer #(
  parameter int ADDR_W = 33,
  parameter int T_RCD  = 39,
  parameter int T_RTP  = 18,
  parameter int T_WR   = 30,
  parameter int T_RP   = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  output logic [2:0]        cmd_code,
  output logic [2:0]        cmd_bg,
  output logic [1:0]        cmd_bank,
  output logic [15:0]       cmd_row,
  output logic [9:0]        cmd_col,
  output logic              err_op,
  output logic              busy
);

  // Counter is wide enough for the largest spacing and only ever counts down.
  localparam int T_MAX_A = (T_RCD > T_RTP) ? T_RCD : T_RTP;
  localparam int T_MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_WAIT_RCD = 3'd2,
    S_COL      = 3'd3,
    S_WAIT_COL = 3'd4,
    S_PRE      = 3'd5,
    S_WAIT_RP  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q;
  logic [2:0]       bg_q;
  logic [1:0]       bank_q;
  logic [15:0]      row_q;
  logic [9:0]       col_q;
  logic             err_q;
  logic             accept;
  logic             accept_legal;
  cmd_t             code;
  logic             unused_addr_bits;

  // Byte-offset bits below the column field carry no command information.
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  assign accept_legal = accept && (req_op != OP_ILLEGAL);

  assign cmd_code = code;
  assign cmd_bg   = bg_q;
  assign cmd_bank = bank_q;
  assign cmd_row  = row_q;
  assign cmd_col  = col_q;
  assign err_op   = err_q;
  assign busy     = (state_q != S_IDLE);

  // Next-state, spacing counter and command outputs.
  // Each wait state holds (T-1) cycles; a spacing of 1 skips the wait state
  // so the next command lands in the cycle right after the previous one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_valid = 1'b0;
    code      = CMD_NOP;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_legal) begin
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        cmd_valid = 1'b1;
        code      = CMD_ACT;
        if (T_RCD <= 1) begin
          state_d = S_COL;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT_RCD;
          cnt_d   = CNT_W'(T_RCD - 1);
        end
      end
      S_WAIT_RCD: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_COL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COL: begin
        cmd_valid = 1'b1;
        code      = is_wr_q ? CMD_WR : CMD_RD;
        if (is_wr_q ? (T_WR <= 1) : (T_RTP <= 1)) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT_COL;
          cnt_d   = is_wr_q ? CNT_W'(T_WR - 1) : CNT_W'(T_RTP - 1);
        end
      end
      S_WAIT_COL: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        code      = CMD_PRE;
        if (T_RP <= 1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = CNT_W'(T_RP - 1);
        end
      end
      S_WAIT_RP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register, counter and per-request field capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      bg_q    <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && (req_op == OP_ILLEGAL);
      if (accept_legal) begin
        is_wr_q <= (req_op == OP_WRITE);
        col_q   <= req_addr[11:2];
        bank_q  <= req_addr[13:12];
        bg_q    <= req_addr[16:14];
        row_q   <= req_addr[32:17];
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Bench for dram_cmd_issuer: two instances (short spacings and all-ones
// spacings) driven by directed steps; expected commands with their cycle
// numbers are queued when a request is driven and popped as commands appear.
module tb_dram_cmd_issuer;

  localparam int A_RCD = 3;
  localparam int A_RTP = 2;
  localparam int A_WR  = 4;
  localparam int A_RP  = 2;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;

  typedef struct {
    logic [33:0] f;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic        a_valid, a_ready, a_cmd_valid, a_err, a_busy;
  logic [1:0]  a_op;
  logic [32:0] a_addr;
  logic [2:0]  a_code, a_bg;
  logic [1:0]  a_bank;
  logic [15:0] a_row;
  logic [9:0]  a_col;

  logic        b_valid, b_ready, b_cmd_valid, b_err, b_busy;
  logic [1:0]  b_op;
  logic [32:0] b_addr;
  logic [2:0]  b_code, b_bg;
  logic [1:0]  b_bank;
  logic [15:0] b_row;
  logic [9:0]  b_col;

  dram_cmd_issuer #(.ADDR_W(33), .T_RCD(A_RCD), .T_RTP(A_RTP), .T_WR(A_WR), .T_RP(A_RP)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
    .req_addr(a_addr), .cmd_valid(a_cmd_valid), .cmd_code(a_code), .cmd_bg(a_bg),
    .cmd_bank(a_bank), .cmd_row(a_row), .cmd_col(a_col), .err_op(a_err), .busy(a_busy)
  );

  dram_cmd_issuer #(.ADDR_W(33), .T_RCD(1), .T_RTP(1), .T_WR(1), .T_RP(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
    .req_addr(b_addr), .cmd_valid(b_cmd_valid), .cmd_code(b_code), .cmd_bg(b_bg),
    .cmd_bank(b_bank), .cmd_row(b_row), .cmd_col(b_col), .err_op(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected field vector {bg, bank, row, col} from the address map.
  function automatic logic [30:0] fields(input logic [32:0] addr);
    return {addr[16:14], addr[13:12], addr[32:17], addr[11:2]};
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive one request into instance A at a negedge and check its full sequence.
  task automatic issue_a(input logic [1:0] op, input logic [32:0] addr, input logic [30:0] flds);
    int c0, t_col, t_pre, t_rdy;
    exp_t e;
    chk("a_ready_before", a_ready, 1);
    c0 = cyc;
    a_valid = 1'b1;
    a_op = op;
    a_addr = addr;
    t_col = c0 + 1 + A_RCD;
    t_pre = t_col + ((op == 2'd1) ? A_WR : A_RTP);
    t_rdy = t_pre + A_RP;
    e.f = {C_ACT, flds}; e.c = c0 + 1; qa.push_back(e);
    e.f = {((op == 2'd1) ? C_WR : C_RD), flds}; e.c = t_col; qa.push_back(e);
    e.f = {C_PRE, flds}; e.c = t_pre; qa.push_back(e);
    @(negedge clk);
    a_valid = 1'b0;
    a_addr = {$urandom, $urandom};
    a_op = 2'($urandom);
    chk("a_busy_after_accept", a_busy, 1);
    chk("a_ready_after_accept", a_ready, 0);
    chk("a_err_legal", a_err, 0);
    for (int n = 0; n < 200 && a_ready !== 1'b1; n++) @(negedge clk);
    chk("a_ready_cycle", cyc, t_rdy);
  endtask

  // Scoreboard monitor for instance A.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_cmd_valid === 1'b1) begin
        chk("a_cmd_expected", qa.size() != 0, 1);
        chk("a_busy_on_cmd", a_busy, 1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          chk("a_cmd_fields", {a_code, a_bg, a_bank, a_row, a_col}, ea.f);
          chk("a_cmd_cycle", cyc, ea.c);
        end
      end else begin
        chk("a_nop_between", {a_cmd_valid, a_code}, {1'b0, C_NOP});
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b_cmd_valid === 1'b1) begin
        chk("b_cmd_expected", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          chk("b_cmd_fields", {b_code, b_bg, b_bank, b_row, b_col}, eb.f);
          chk("b_cmd_cycle", cyc, eb.c);
        end
      end else begin
        chk("b_nop_between", {b_cmd_valid, b_code}, {1'b0, C_NOP});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] x_addr, y_addr, r_addr;
    logic [1:0]  r_op;
    int          c0;
    exp_t        e;

    rst = 1'b1;
    a_valid = 1'b0; a_op = '0; a_addr = '0;
    b_valid = 1'b0; b_op = '0; b_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a",
        {a_ready, a_cmd_valid, a_code, a_bg, a_bank, a_row, a_col, a_err, a_busy}, 0);
    chk("reset_ready_b", b_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset_a", a_ready, 1);
    chk("ready_after_reset_b", b_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);

    // Directed read, write and fetch.
    issue_a(2'd0, 33'h1576554, {3'd5, 2'd2, 16'h00AB, 10'h155});
    issue_a(2'd1, 33'h1576554, {3'd5, 2'd2, 16'h00AB, 10'h155});
    issue_a(2'd2, 33'h0, 31'h0);

    // Illegal op: flagged, dropped, and a read is accepted right after.
    a_valid = 1'b1; a_op = 2'd3; a_addr = {$urandom, $urandom};
    @(negedge clk);
    a_valid = 1'b0;
    chk("illegal_err_pulse", a_err, 1);
    chk("illegal_busy", a_busy, 0);
    chk("illegal_ready", a_ready, 1);
    r_addr = {$urandom, $urandom};
    issue_a(2'd0, r_addr, fields(r_addr));

    // A few random reads/writes.
    for (int i = 0; i < 4; i++) begin
      r_addr = {$urandom, $urandom};
      r_op = 2'($urandom_range(0, 2));
      issue_a(r_op, r_addr, fields(r_addr));
    end

    // Reset between WR and PRE: the PRE must never appear.
    c0 = cyc;
    a_valid = 1'b1; a_op = 2'd1; a_addr = 33'h1576554;
    e.f = {C_ACT, 3'd5, 2'd2, 16'h00AB, 10'h155}; e.c = c0 + 1; qa.push_back(e);
    e.f = {C_WR, 3'd5, 2'd2, 16'h00AB, 10'h155}; e.c = c0 + 1 + A_RCD; qa.push_back(e);
    @(negedge clk);
    a_valid = 1'b0;
    wait_cyc(c0 + 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs",
        {a_ready, a_cmd_valid, a_code, a_bg, a_bank, a_row, a_col, a_err, a_busy}, 0);
    rst = 1'b0;
    #1;
    chk("mid_reset_ready", a_ready, 1);
    repeat (12) @(negedge clk);
    chk("mid_reset_no_pre", qa.size(), 0);

    // Back-to-back reads with req_valid held, all spacings 1.
    x_addr = 33'h1576554;
    y_addr = {$urandom, $urandom};
    c0 = cyc;
    b_valid = 1'b1; b_op = 2'd0; b_addr = x_addr;
    e.f = {C_ACT, fields(x_addr)}; e.c = c0 + 1; qb.push_back(e);
    e.f = {C_RD,  fields(x_addr)}; e.c = c0 + 2; qb.push_back(e);
    e.f = {C_PRE, fields(x_addr)}; e.c = c0 + 3; qb.push_back(e);
    e.f = {C_ACT, fields(y_addr)}; e.c = c0 + 5; qb.push_back(e);
    e.f = {C_RD,  fields(y_addr)}; e.c = c0 + 6; qb.push_back(e);
    e.f = {C_PRE, fields(y_addr)}; e.c = c0 + 7; qb.push_back(e);
    @(negedge clk);
    b_addr = y_addr;
    chk("b2b_busy_first", b_busy, 1);
    wait_cyc(c0 + 3);
    chk("b2b_not_ready_at_pre", b_ready, 0);
    wait_cyc(c0 + 4);
    chk("b2b_ready_gap", b_ready, 1);
    wait_cyc(c0 + 5);
    b_valid = 1'b0;
    chk("b2b_busy_second", b_busy, 1);
    wait_cyc(c0 + 8);
    chk("b2b_ready_end", b_ready, 1);
    chk("b2b_no_err", b_err, 0);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
